amplitude_rng: RTL and testbench

//  Upstream stage of obstacle_control: supplies y_amplitude_in, the random extra arc height per obstacle spawn.
//  A free-running Galois LFSR is sampled on request, range-reduced to 0..AMP_MAX and quantised to AMP_STEP.

---
 rtl/amplitude_rng_pkg.sv | 30 +++
 rtl/amplitude_rng_if.sv | 21 ++
 rtl/amplitude_rng_lfsr16.sv | 38 +++
 rtl/amplitude_rng.sv | 126 ++++++++++++
 tb/tb_amplitude_rng.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/amplitude_rng_pkg.sv
// Shared constants, FSM state type and LFSR step helper for the amplitude generator.
// No timing of its own; consumed by amplitude_rng and its LFSR.
// No flow control.
package amplitude_rng_pkg;

  // Obstacle horizontal speed; amplitudes are quantised to the same step.
  localparam logic [9:0]  OBSTACLE_X_SPEED = 10'd5;

  localparam logic [15:0] SEED_DEF      = 16'hACE1;
  localparam logic [9:0]  AMP_MAX_DEF   = 10'd150;
  localparam logic [9:0]  AMP_STEP_DEF  = OBSTACLE_X_SPEED;
  localparam logic [9:0]  MIN_DELTA_DEF = 10'd20;
  localparam logic [1:0]  MAX_RETRY_DEF = 2'd3;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_REDUCE = 3'd2,
    ST_QUANT  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  // One right shift of the Galois LFSR; the mask is applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/amplitude_rng_if.sv
// Request / result bundle between the obstacle controller and the amplitude generator.
// Pure wiring, no latency.
// No backpressure: new_req is a pulse, amp_valid a one-cycle strobe.
interface amplitude_rng_if;
  logic        new_req;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [9:0]  y_amplitude_out;
  logic        amp_valid;
  logic        busy;

  modport master (
    output new_req, seed_load, seed_in,
    input  y_amplitude_out, amp_valid, busy
  );

  modport slave (
    input  new_req, seed_load, seed_in,
    output y_amplitude_out, amp_valid, busy
  );
endinterface

// File: rtl/amplitude_rng_lfsr16.sv
// Free-running 16-bit Galois LFSR with synchronous seed load and zero-seed guard.
// Latency: a load or shift is visible the cycle after the clock edge.
// Never stalls; seed_load simply overrides the shift for one cycle.
module amplitude_rng_lfsr16
  import amplitude_rng_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed_in,
  output logic [15:0] state_out
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: load wins over shift; an all-zero seed would lock up, so fall back to SEED.
  always_comb begin
    state_d = lfsr_step(state_q);
    if (load) begin
      state_d = (seed_in == 16'h0000) ? SEED : seed_in;
    end
  end

  // State register with synchronous reset to the fixed seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: rtl/amplitude_rng.sv
// Produces a random, step-quantised obstacle arc amplitude on request, avoiding repeats.
// Latency: 5 clks minimum, bounded by 4 attempts of sample/reduce/quantise/check plus commit.
// Requests arriving while busy are dropped; the output holds until the next commit.
module amplitude_rng
  import amplitude_rng_pkg::*;
#(
  parameter logic [15:0] SEED      = SEED_DEF,
  parameter logic [9:0]  AMP_MAX   = AMP_MAX_DEF,
  parameter logic [9:0]  AMP_STEP  = AMP_STEP_DEF,
  parameter logic [9:0]  MIN_DELTA = MIN_DELTA_DEF,
  parameter logic [1:0]  MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  amplitude_rng_if.slave  bus
);

  state_e      state_q, state_d;
  logic [9:0]  work_q, work_d;
  logic [9:0]  rem_q, rem_d;
  logic [9:0]  prev_q, prev_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] lfsr_state;
  logic [10:0] diff;
  logic        lfsr_unused;

  amplitude_rng_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.seed_load),
    .seed_in   (bus.seed_in),
    .state_out (lfsr_state)
  );

  // Only the low 10 bits feed the sample; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_state[15:10];

  // Distance to the previous amplitude, widened so it never wraps.
  always_comb begin
    if (work_q >= prev_q) begin
      diff = {1'b0, work_q} - {1'b0, prev_q};
    end else begin
      diff = {1'b0, prev_q} - {1'b0, work_q};
    end
  end

  // Next-state and datapath: sample, modular reduction, quantisation, distance check.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    prev_d  = prev_q;
    y_d     = y_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.new_req) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        work_d  = lfsr_state[9:0];
        state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        if (work_q > AMP_MAX) begin
          work_d = work_q - (AMP_MAX + 10'd1);
        end else begin
          rem_d   = work_q;
          state_d = ST_QUANT;
        end
      end
      ST_QUANT: begin
        if (rem_q >= AMP_STEP) begin
          rem_d = rem_q - AMP_STEP;
        end else begin
          work_d  = work_q - rem_q;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((diff < {1'b0, MIN_DELTA}) && (retry_q < MAX_RETRY)) begin
          retry_d = retry_q + 2'd1;
          state_d = ST_SAMPLE;
        end else begin
          // Load the result here so it is already on the output during the valid strobe.
          y_d     = work_q;
          prev_d  = work_q;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        retry_d = 2'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      prev_q  <= '0;
      y_q     <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      prev_q  <= prev_d;
      y_q     <= y_d;
      retry_q <= retry_d;
    end
  end

  assign bus.y_amplitude_out = y_q;
  assign bus.amp_valid       = (state_q == ST_COMMIT);
  assign bus.busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_amplitude_rng.sv
// Self-checking bench for amplitude_rng: directed forced samples plus model-checked requests.
// Latency of each request is checked against a cycle-count model of the algorithm.
// Requests are issued only from idle, except where dropping extras is being exercised.
module tb_amplitude_rng;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  amplitude_rng_if amp_if ();

  amplitude_rng dut (
    .clk (clk),
    .rst (rst),
    .bus (amp_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] lfsr_m;
  logic [9:0]  fv [4];
  int          nvals;
  int          samp_off [4];
  int          n_att;
  int          prev_m;
  int          prev_obs;

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Shadow of the DUT LFSR, following reset, seed loads and shifts.
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else if (amp_if.seed_load) lfsr_m <= (amp_if.seed_in == 16'h0000) ? 16'hACE1 : amp_if.seed_in;
    else lfsr_m <= step(lfsr_m);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Algorithm model: value committed, cycle offset of amp_valid, whether retries ran out.
  // l0 is the LFSR value in the cycle the request is accepted.
  task automatic model_req(input logic [15:0] l0, input bit frc, input int prv,
                           output int val, output int lat, output bit exh);
    logic [15:0] lf;
    int off, s, w, nsub, q, d, len;
    lf = step(l0);
    off = 1; val = 0; lat = 0; exh = 0; n_att = 0;
    for (int a = 0; a < 4; a++) begin
      samp_off[a] = off;
      n_att = a + 1;
      s = frc ? int'(fv[(a < nvals) ? a : nvals - 1]) : int'(lf[9:0]);
      w = s; nsub = 0;
      while (w > 150) begin w = w - 151; nsub++; end
      q = w - (w % 5);
      len = 1 + (nsub + 1) + (w / 5 + 1) + 1;
      d = (q > prv) ? q - prv : prv - q;
      if (d < 20 && a < 3) begin
        off = off + len;
        for (int i = 0; i < len; i++) lf = step(lf);
      end else begin
        val = q; lat = off + len; exh = (d < 20);
        break;
      end
    end
  endtask

  // Issue one request from the current negedge (DUT idle); returns at the negedge after commit.
  task automatic do_req(input bit frc, input bit hold, input bit spam, input string tag,
                        output int got_val, output int got_lat);
    int ev, el, j, y;
    bit ex, seen;
    model_req(lfsr_m, frc, prev_m, ev, el, ex);
    amp_if.new_req = 1'b1;
    if (frc) begin
      amp_if.seed_load = 1'b1;
      amp_if.seed_in   = {6'd0, fv[0]};
    end else begin
      amp_if.seed_load = 1'b0;
    end
    j = 0; seen = 0; got_lat = -1; got_val = -1;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (amp_if.amp_valid) begin
        seen = 1; got_lat = k;
        break;
      end
      if (k == 1) chk({tag, "_busy"}, int'(amp_if.busy), 1);
      if (frc && j < n_att && k == samp_off[j]) begin
        amp_if.seed_in = {6'd0, fv[(j + 1 < nvals) ? j + 1 : nvals - 1]};
        j++;
      end
      if (!hold) amp_if.new_req = spam && (k % 3 == 0);
    end
    if (!hold) amp_if.new_req = 1'b0;
    amp_if.seed_load = 1'b0;
    chk({tag, "_valid_seen"}, int'(seen), 1);
    y = int'(amp_if.y_amplitude_out);
    got_val = y;
    if (seen) begin
      chk({tag, "_val"}, y, ev);
      chk({tag, "_lat"}, got_lat, el);
      chk({tag, "_range"}, int'(y <= 150), 1);
      chk({tag, "_step"}, y % 5, 0);
      if (!ex) chk({tag, "_delta"}, int'(((y > prev_obs) ? y - prev_obs : prev_obs - y) >= 20), 1);
    end
    prev_m = ev;
    prev_obs = y;
    @(negedge clk);
    chk({tag, "_pulse_one"}, int'(amp_if.amp_valid), 0);
    chk({tag, "_idle"}, int'(amp_if.busy), 0);
  endtask

  initial begin
    int v, l, cnt;
    amp_if.new_req   = 1'b1;
    amp_if.seed_load = 1'b0;
    amp_if.seed_in   = 16'h0000;
    rst = 1'b1;
    prev_m = 0; prev_obs = 0; nvals = 1;
    for (int i = 0; i < 4; i++) fv[i] = 10'd0;

    // Reset held with new_req high: nothing moves.
    repeat (3) begin
      @(negedge clk);
      chk("rst_y", int'(amp_if.y_amplitude_out), 0);
      chk("rst_valid", int'(amp_if.amp_valid), 0);
      chk("rst_busy", int'(amp_if.busy), 0);
    end
    rst = 1'b0;
    amp_if.new_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", int'(amp_if.busy), 0);

    // 151 reduces to 0; prev=0 so all retries burn: 4 attempts of 5 clks + commit.
    fv[0] = 10'd151; nvals = 1;
    do_req(1'b1, 1'b0, 1'b0, "f151", v, l);
    chk("f151_hand_val", v, 0);
    chk("f151_hand_lat", l, 21);

    // 1023 -> 117 after six subtracts -> 115 after quantising.
    @(negedge clk);
    fv[0] = 10'd1023; nvals = 1;
    do_req(1'b1, 1'b0, 1'b0, "f1023", v, l);
    chk("f1023_hand_val", v, 115);
    chk("f1023_hand_lat", l, 34);

    // 100 is within 20 of 115, constant source, so retries exhaust and 100 is taken.
    @(negedge clk);
    fv[0] = 10'd100; nvals = 1;
    do_req(1'b1, 1'b0, 1'b0, "f100", v, l);
    chk("f100_hand_val", v, 100);
    chk("f100_hand_lat", l, 97);

    // prev=100: 110,105,95 rejected, 90 accepted once retries run out.
    @(negedge clk);
    fv[0] = 10'd110; fv[1] = 10'd105; fv[2] = 10'd95; fv[3] = 10'd90; nvals = 4;
    do_req(1'b1, 1'b0, 1'b0, "retry", v, l);
    chk("retry_hand_val", v, 90);
    chk("retry_hand_lat", l, 97);

    // Zero seed falls back to the default seed; shadow must then track exactly.
    @(negedge clk);
    amp_if.seed_load = 1'b1;
    amp_if.seed_in   = 16'h0000;
    @(negedge clk);
    amp_if.seed_load = 1'b0;
    chk("seed_zero", int'(dut.lfsr_state), int'(16'hACE1));
    repeat (6) begin
      @(negedge clk);
      chk("lfsr_track", int'(dut.lfsr_state), int'(lfsr_m));
    end

    // Seed 0x0064, request one clock later; value from the model.
    amp_if.seed_load = 1'b1;
    amp_if.seed_in   = 16'h0064;
    @(negedge clk);
    amp_if.seed_load = 1'b0;
    do_req(1'b0, 1'b0, 1'b0, "seed64", v, l);

    // Extra requests while busy are dropped: exactly one commit, then silence.
    @(negedge clk);
    do_req(1'b0, 1'b0, 1'b1, "spam", v, l);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (amp_if.amp_valid) cnt++;
    end
    chk("spam_no_extra", cnt, 0);

    // 200 back-to-back requests with new_req held high throughout.
    for (int i = 0; i < 200; i++) do_req(1'b0, 1'b1, 1'b0, "b2b", v, l);
    amp_if.new_req = 1'b0;
    @(negedge clk);

    // Reset in mid-operation: no commit leaks out afterwards.
    amp_if.new_req = 1'b1;
    @(negedge clk);
    amp_if.new_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_y", int'(amp_if.y_amplitude_out), 0);
    chk("midrst_busy", int'(amp_if.busy), 0);
    chk("midrst_valid", int'(amp_if.amp_valid), 0);
    rst = 1'b0;
    prev_m = 0; prev_obs = 0;
    cnt = 0;
    repeat (170) begin
      @(negedge clk);
      if (amp_if.amp_valid) cnt++;
    end
    chk("midrst_no_commit", cnt, 0);
    do_req(1'b0, 1'b0, 1'b0, "post_midrst", v, l);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
